// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: forwards register operands, selects the immediate for SrcB and
// buffers results in a two-entry skid buffer. Define EX_OPERAND_FWD_EN to enable MEM/WB forwarding.
module ex_operand_stage #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [WIDTH-1:0]      in_rs1_data,
  input  logic [WIDTH-1:0]      in_rs2_data,
  input  logic [WIDTH-1:0]      in_imm,
  input  logic                  in_alusrc,
  input  logic [3:0]            in_aluctrl,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic                  in_regwrite,
  input  logic                  fwd_mem_valid,
  input  logic                  fwd_wb_valid,
  input  logic [REG_ADDR_W-1:0] fwd_mem_rd,
  input  logic [REG_ADDR_W-1:0] fwd_wb_rd,
  input  logic [WIDTH-1:0]      fwd_mem_data,
  input  logic [WIDTH-1:0]      fwd_wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      SrcA,
  output logic [WIDTH-1:0]      SrcB,
  output logic [3:0]            ALUctrl,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic                  out_regwrite
);

  typedef struct packed {
    logic [WIDTH-1:0]      srca;
    logic [WIDTH-1:0]      srcb;
    logic [3:0]            ctrl;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rw;
  } entry_t;

  entry_t m_q, m_d, s_q, s_d, in_entry;
  logic   m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic   accept, m_free;
  logic [WIDTH-1:0] rs1_val, rs2_val;

`ifdef EX_OPERAND_FWD_EN
  // MEM is the younger result, so it wins over WB; x0 is never forwarded.
  function automatic logic [WIDTH-1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic [WIDTH-1:0]      rf,
    input logic                  mem_v,
    input logic [REG_ADDR_W-1:0] mem_rd,
    input logic [WIDTH-1:0]      mem_d,
    input logic                  wb_v,
    input logic [REG_ADDR_W-1:0] wb_rd,
    input logic [WIDTH-1:0]      wb_d
  );
    if (mem_v && (mem_rd == src) && (src != '0)) return mem_d;
    if (wb_v && (wb_rd == src) && (src != '0)) return wb_d;
    return rf;
  endfunction

  assign rs1_val = fwd_sel(in_rs1_addr, in_rs1_data, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                           fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
  assign rs2_val = fwd_sel(in_rs2_addr, in_rs2_data, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                           fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_mem_valid, fwd_wb_valid, fwd_mem_rd, fwd_wb_rd,
                        fwd_mem_data, fwd_wb_data, in_rs1_addr, in_rs2_addr};
  assign rs1_val = in_rs1_data;
  assign rs2_val = in_rs2_data;
`endif

  always_comb begin
    in_entry      = '0;
    in_entry.srca = rs1_val;
    in_entry.srcb = in_alusrc ? in_imm : rs2_val;
    in_entry.ctrl = in_aluctrl;
    in_entry.rd   = in_rd_addr;
    in_entry.rw   = in_regwrite;
  end

  assign in_ready = !s_valid_q;
  assign accept   = in_valid && in_ready;
  assign m_free   = !m_valid_q || out_ready;

  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (flush) begin
      m_d       = '0;
      s_d       = '0;
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (m_free) begin
      // S holds the older entry, so it drains ahead of any new input.
      if (s_valid_q) begin
        m_d       = s_q;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else if (accept) begin
        m_d       = in_entry;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_d       = in_entry;
      s_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= '0;
      s_q       <= '0;
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      s_q       <= s_d;
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
    end
  end

  assign out_valid    = m_valid_q;
  assign SrcA         = m_q.srca;
  assign SrcB         = m_q.srcb;
  assign ALUctrl      = m_q.ctrl;
  assign out_rd_addr  = m_q.rd;
  assign out_regwrite = m_q.rw;

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline stage that sits directly upstream of the execute-stage ALU and drives its `SrcA`, `SrcB` and `ALUctrl` inputs. Each cycle it accepts one decoded instruction's operands from decode, resolves register operands against the MEM and WB result buses (forwarding), and selects the immediate or the register value for `SrcB`. The result is held in a two-entry skid buffer with a valid/ready handshake, so downstream backpressure never creates a combinational ready path back into decode.

## Interface

- `WIDTH`, 32, datapath width
- `REG_ADDR_W`, 5, register address width

- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous kill of all buffered entries
- `in_valid`  in  1  decode presents an instruction
- `in_ready`  out  1  stage can accept an instruction
- `in_rs1_addr`, `in_rs2_addr`  in  REG_ADDR_W  source register addresses
- `in_rs1_data`, `in_rs2_data`  in  WIDTH  register file read data
- `in_imm`  in  WIDTH  sign-extended immediate
- `in_alusrc`  in  1  1 selects `in_imm` for `SrcB`
- `in_aluctrl`  in  4  ALU operation code, passed through unchanged
- `in_rd_addr`  in  REG_ADDR_W  destination register
- `in_regwrite`  in  1  instruction writes `rd`
- `fwd_mem_valid`, `fwd_wb_valid`  in  1  the MEM or WB stage writes a register this cycle
- `fwd_mem_rd`, `fwd_wb_rd`  in  REG_ADDR_W  MEM and WB destination registers
- `fwd_mem_data`, `fwd_wb_data`  in  WIDTH  MEM and WB result values
- `out_valid`  out  1  the ALU operands are valid
- `out_ready`  in  1  execute consumes the entry
- `SrcA`, `SrcB`  out  WIDTH  ALU operands
- `ALUctrl`  out  4  ALU operation code
- `out_rd_addr`  out  REG_ADDR_W  destination register
- `out_regwrite`  out  1  write enable

## Operation

- **Storage.** Two entries: main (M) and skid (S).
  - M drives all outputs; `out_valid` = M.valid.
  - `in_ready` = !S.valid. This is a pure register output.
- **Forwarding, per source operand.**
  - The MEM bus is used if `fwd_mem_valid` is 1, `fwd_mem_rd` equals the source address and the source address is not 0.
  - Otherwise the WB bus is used under the same conditions.
  - Otherwise the register file data is used.
  - MEM has priority over WB. Forwarding is evaluated only in the acceptance cycle; the buffered value is not updated afterwards.
- **Operand selection.**
  - `SrcA` is the forwarded rs1 value.
  - `SrcB` is `in_imm` if `in_alusrc` is 1, otherwise the forwarded rs2 value.
- **Accept.** An instruction is accepted when `in_valid` and `in_ready` are both 1.
- **Load rules, at each edge without flush:**
  - If M is empty, or M is consumed (`out_valid` and `out_ready` both 1): M loads S when S is valid (S then clears), else M loads the accepted input. If there is neither, M.valid clears.
  - If M is stalled (`out_valid` 1, `out_ready` 0) and an input is accepted, the input goes to S.
- **Payload retention.** When an entry empties, its payload keeps its last value.
- **Flush.**
  - M.valid and S.valid clear at the next edge, and all payload registers are zeroed.
  - An input presented in the same cycle is dropped.
  - A consume presented in the same cycle is still a consume from the execute stage's point of view.
  - Flush has priority over every other update.
- **Reset values.**
  - `out_valid`=0, `in_ready`=1.
  - `SrcA`=`SrcB`=0, `ALUctrl`=0, `out_rd_addr`=0, `out_regwrite`=0.
  - S is empty.

## Timing

- **Latency.** An instruction accepted at edge N is on the outputs with `out_valid`=1 in cycle N+1, with no stall.
- **Throughput.** One instruction per cycle while `out_ready` is held at 1.
- **Stall.**
  - The first stalled cycle accepts one more input into S.
  - `in_ready` drops to 0 in the following cycle.
- **Output stability.** Outputs are stable while `out_valid`=1 and `out_ready`=0.
- **Consume with S full.** S moves into M at the edge, and `in_ready` returns to 1 in the next cycle.
- **Ordering.** Entries leave in acceptance order. There is no loss or duplication.
- **Paths.** There is no combinational path from `out_ready` to `in_ready`. Forwarding and immediate muxing are combinational on the input side only.
- **Reset during operation.** Asserting `rst_n` low clears both entries immediately, without waiting for a clock edge.

## Configuration

- **`EX_OPERAND_FWD_EN` defined:** forwarding operates as described above.
- **`EX_OPERAND_FWD_EN` not defined:**
  - The `fwd_*` ports remain present but are ignored.
  - `SrcA` = `in_rs1_data`, and `SrcB` = `in_imm` or `in_rs2_data`.
  - Hazards are the decode stall logic's responsibility.

## Test plan

- **Reset.** Reset, then present no input: `out_valid`=0, `in_ready`=1, and all outputs are 0.
- **Streaming.**
  - Stimulus: `out_ready`=1, and back-to-back instructions with rs1 data 5/6/7, rs2 data 3, and `in_aluctrl`=4'b0001.
  - Required response: `SrcA` shows 5, 6, 7 on consecutive cycles, one cycle after each accept.
- **Forwarding priority.**
  - Stimulus: rs1=x3. MEM(rd=x3, data 0xAA) and WB(rd=x3, data 0xBB) are both valid.
  - Required response: `SrcA`=0xAA.
  - Stimulus: rs1=x0 with MEM rd=x0.
  - Required response: `SrcA` equals the register file data. With `EX_OPERAND_FWD_EN` undefined, `SrcA` also equals the register file data.
- **Immediate select.** `in_alusrc`=1, `in_imm`=0xFFFFFFF0, `in_rs2_data`=9 -> `SrcB`=0xFFFFFFF0.
- **Backpressure.**
  - Stimulus: hold `out_ready`=0 and offer A, B, C.
  - Required response: A and B are accepted and `in_ready`=0 for C.
  - Stimulus: raise `out_ready`.
  - Required response: A, B and C emerge in order, with no drop or duplication.
- **Flush and asynchronous reset.**
  - Stimulus: both entries full, assert `flush` together with `in_valid`.
  - Required response: next cycle `out_valid`=0, `in_ready`=1, outputs are 0, and the input is dropped.
  - Stimulus: assert `rst_n` low mid-stream, between clock edges.
  - Required response: `out_valid` falls immediately.
